input_debounce_8: RTL
=====================

// Module: input_debounce_8
// PURPOSE
//   Upstream stage of the 8-to-3 encoder. Synchronises 8 raw request lines,
//   debounces them as one vector, and publishes the settled vector on d.
//   Drives the encoder's active-low enable en: en=1 disables the encoder
//   while the input is unsettled or after reset; en=0 once d is valid.
// PARAMETERS
//   WIDTH            8   request vector width; fixed 8 to match the encoder
//   DEBOUNCE_CYCLES  4   consecutive equal synchronised samples required; >=1
//   CNT_W            3   counter width; must satisfy 2**CNT_W >= DEBOUNCE_CYCLES
// PORTS
//   clk        in   1  single clock, rising-edge
//   rst        in   1  asynchronous, active-high reset
//   raw_in     in   8  asynchronous request lines (switches/buttons)
//   d          out  8  settled request vector, to encoder d
//   en         out  1  encoder enable, active low (1 = encoder disabled)
//   change     out  1  one-cycle pulse when d takes a new, different value
//   multi_err  out  1  multiple-bit settled value rejected (ONEHOT_CHECK_EN only)
// BEHAVIOUR
//   Reset (async): d=0, en=1, change=0, multi_err=0, sync regs=0, cand=0,
//     cnt=0, state=IDLE. Reset asserted mid-SETTLE aborts with no update.
//   Sync: raw_in -> 2-flop synchroniser -> sync (2-cycle delay).
//   FSM, all registered:
//     IDLE   : cand<=sync, cnt<=0 -> SETTLE (first cycle after reset)
//     SETTLE : en held 1. sync!=cand: cand<=sync, cnt<=0, stay (bounce).
//              sync==cand && cnt==DEBOUNCE_CYCLES-1: d<=cand, en<=0,
//              change<=(cand!=d) -> STABLE. Otherwise cnt<=cnt+1.
//     STABLE : sync==d: hold, change<=0. sync!=d: cand<=sync, cnt<=0,
//              en<=1 -> SETTLE.
//   Latency: raw change before edge k -> d/en/change update at edge
//     k+2+DEBOUNCE_CYCLES if raw_in stays constant.
//   change pulses exactly one cycle; never asserts when settled value equals d
//     (glitch that returns to old value: en toggles 1 then back to 0, change=0).
//   sync changing on the terminal-count cycle: bounce rule wins, no update.
//   cnt never exceeds DEBOUNCE_CYCLES-1; no wrap.
//   d changes only on the SETTLE->STABLE transition; never mid-bounce.
// CONFIGURATION
//   ONEHOT_CHECK_EN defined: in SETTLE at terminal count, if cand has >1 bit
//     set, d keeps old value, en stays 1, multi_err<=1, state->STABLE with
//     comparison against cand (no re-settle until sync changes); multi_err
//     clears when a legal (0 or one-hot) value is published.
//   Undefined: any settled value published; multi_err tied 0.
// STRUCTURE
//   Shared header input_debounce_defs.vh: state encodings S_IDLE=2'd0,
//     S_SETTLE=2'd1, S_STABLE=2'd2; default DEBOUNCE_CYCLES.
//   One sub-module: sync_2ff (WIDTH-bit two-flop synchroniser, async rst).
//   Top: FSM, counter, cand/d/en/change/multi_err registers.
// TESTING (DEBOUNCE_CYCLES=4, 10 ns clk)
//   1 rst pulse mid-run -> d=0, en=1, change=0 immediately, before clk edge.
//   2 raw_in 00->04 held -> d=04, en=0, change=1 for one cycle, 6 edges after.
//   3 raw_in 01, bounce 01/00/01 every 2 cycles, then held 01 -> no d update
//     during bounce; d=01 exactly 6 edges after last edge of bounce.
//   4 d=08 stable, raw_in pulses 00 for 2 cycles -> en=1 during settle, then
//     en=0, d stays 08, change never asserts.
//   5 raw_in 40 -> 80 changing on terminal-count cycle -> d skips 40, goes 80.
//   6 ONEHOT_CHECK_EN: raw_in 03 held -> d keeps old value, en=1,
//     multi_err=1; then 02 -> d=02, en=0, multi_err=0.

Source files
------------

// File: rtl/input_debounce_8_pkg.sv
// Shared definitions for the input_debounce_8 request-line conditioner:
// FSM state encodings, default debounce length and the multi-hot test.
package input_debounce_8_pkg;

    localparam int WIDTH               = 8;
    localparam int DEBOUNCE_CYCLES_DEF = 4;

    typedef logic [1:0] state_t;

    localparam state_t S_IDLE   = 2'd0;
    localparam state_t S_SETTLE = 2'd1;
    localparam state_t S_STABLE = 2'd2;

    // More than one bit set: clearing the lowest set bit leaves something behind.
    function automatic logic is_multi_hot(input logic [WIDTH-1:0] v);
        return (v & (v - WIDTH'(1))) != '0;
    endfunction

endpackage

// File: rtl/input_debounce_8_sync_2ff.sv
// WIDTH-bit two-flop synchroniser for asynchronous request lines.
// The output lags the input by two rising clock edges.
module sync_2ff #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] meta;

    // NOTE: non-blocking assignments make both stages sample on the same edge,
    // so din really takes two edges to reach dout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= '0;
            dout <= '0;
        end else begin
            meta <= din;
            dout <= meta;
        end
    end

endmodule

// File: rtl/input_debounce_8.sv
// Synchronises and debounces 8 request lines as one vector for the 8-to-3
// encoder; optional one-hot rejection is built when ONEHOT_CHECK_EN is defined.
module input_debounce_8
    import input_debounce_8_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int CNT_W           = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] raw_in,
    output logic [WIDTH-1:0] d,
    output logic             en,
    output logic             change,
    output logic             multi_err
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync;
    logic [WIDTH-1:0] cand;
    logic [WIDTH-1:0] stable_ref;
    logic [CNT_W-1:0] cnt;
    state_t           state;
    logic             terminal;
    logic             reject;

    sync_2ff #(.WIDTH(WIDTH)) u_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (raw_in),
        .dout (sync)
    );

    // A bounce on the terminal-count cycle must restart the count, not publish.
    assign terminal = (state == S_SETTLE) && (sync == cand) && (cnt == CNT_LAST);

`ifdef ONEHOT_CHECK_EN
    // A rejected value never reaches d, so STABLE must watch cand instead.
    assign stable_ref = cand;
    assign reject     = is_multi_hot(cand);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            multi_err <= 1'b0;
        end else if (terminal) begin
            multi_err <= reject;
        end
    end
`else
    assign stable_ref = d;
    assign reject     = 1'b0;
    assign multi_err  = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            cand   <= '0;
            cnt    <= '0;
            d      <= '0;
            en     <= 1'b1;
            change <= 1'b0;
        end else begin
            // NOTE: a default assignment ahead of the case keeps change a
            // single-cycle pulse without repeating the clear in every branch.
            change <= 1'b0;
            case (state)
                S_IDLE: begin
                    cand  <= sync;
                    cnt   <= '0;
                    state <= S_SETTLE;
                end
                S_SETTLE: begin
                    if (sync != cand) begin
                        cand <= sync;
                        cnt  <= '0;
                    end else if (terminal) begin
                        state <= S_STABLE;
                        if (!reject) begin
                            d      <= cand;
                            en     <= 1'b0;
                            change <= (cand != d);
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_STABLE: begin
                    if (sync != stable_ref) begin
                        cand  <= sync;
                        cnt   <= '0;
                        en    <= 1'b1;
                        state <= S_SETTLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
